uart_rx_capture: RTL and testbench

Synthesizable UART receiver that deserializes 8N1 frames (optional even parity) from the serial line driven by the MicroBlaze UART TX pin and presents each byte through a one-entry holding register with a valid/ack handshake. It sits on the far end of `XUART_TX`. It serves as the loopback and host-side receiver in board builds, and as the capture block in simulation benches that check firmware UART output.

---
 rtl/uart_rx_capture.sv | 123 ++++++++++++
 tb/tb_uart_rx_capture.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_capture.sv
// uart_rx_capture: UART byte receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with a valid/ack holding register
module uart_rx_capture #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       XCLK,
  input  logic       XRESET_N,
  input  logic       XUART_RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_frame_err,
  output logic       rx_overrun,
`ifdef UART_RX_PARITY_EN
  output logic       rx_parity_err,
`endif
  output logic       rx_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP, S_BREAK
  } state_t;
  state_t        r_state, w_state;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0]    r_idx, w_idx;
  logic [7:0]    r_shift, w_shift;
  logic          w_rxs, w_tick, w_deliver, w_ferr, w_ack, w_load;
`ifdef UART_RX_PARITY_EN
  logic          r_par, w_par;
`endif
  assign w_rxs   = r_sync[1];
  assign w_tick  = r_cnt == LAST;
  assign w_ack   = rx_ack & rx_valid;
  assign w_load  = w_deliver & (~rx_valid | w_ack);
  assign rx_busy = r_state != S_IDLE;
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt + CW'(1);
    w_idx     = r_idx;
    w_shift   = r_shift;
    w_deliver = 1'b0;
    w_ferr    = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par     = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt   = '0;
        w_state = w_rxs ? S_IDLE : S_START;
      end
      S_START: if (r_cnt == HALF) begin
        w_cnt   = '0;
        w_idx   = '0;
        w_state = w_rxs ? S_IDLE : S_DATA;
      end
      S_DATA: if (w_tick) begin
        w_cnt   = '0;
        w_shift = {w_rxs, r_shift[7:1]};
        w_idx   = r_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
        w_state = r_idx == 3'd7 ? S_PARITY : S_DATA;
`else
        w_state = r_idx == 3'd7 ? S_STOP : S_DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (w_tick) begin
        w_cnt   = '0;
        w_par   = w_rxs;
        w_state = S_STOP;
      end
`endif
      S_STOP: if (w_tick) begin
        w_cnt     = '0;
        w_deliver = w_rxs;
        w_ferr    = ~w_rxs;
        w_state   = w_rxs ? S_IDLE : S_BREAK;
      end
      S_BREAK: begin
        w_cnt   = '0;
        w_state = w_rxs ? S_IDLE : S_BREAK;
      end
      default: w_state = S_IDLE;
    endcase
  end
  always_ff @(posedge XCLK or negedge XRESET_N) begin
    if (!XRESET_N) begin
      r_state      <= S_IDLE;
      r_sync       <= 2'b11;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par         <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      r_state      <= w_state;
      r_sync       <= {r_sync[0], XUART_RX};
      r_cnt        <= w_cnt;
      r_idx        <= w_idx;
      r_shift      <= w_shift;
      rx_valid     <= w_deliver | (rx_valid & ~w_ack);
      rx_frame_err <= w_ferr;
      rx_overrun   <= ~w_ack & (rx_overrun | (w_deliver & rx_valid));
      if (w_load) rx_data <= r_shift;
`ifdef UART_RX_PARITY_EN
      r_par         <= w_par;
      rx_parity_err <= w_load ? ^{r_shift, r_par} : (~w_ack & rx_parity_err);
`endif
    end
  end
endmodule

// File: tb/tb_uart_rx_capture.sv
// tb_uart_rx_capture: randomized self-checking bench for uart_rx_capture against a frame-level reference
module tb_uart_rx_capture;
  localparam int N = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int LAT = 3 + N / 2 + (NB - 1) * N;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       valid, ferr, ovr, busy;
`ifdef UART_RX_PARITY_EN
  logic       perr;
`endif
  int checks = 0;
  int failures = 0;
  int ferr_cycles = 0;
  int ovr_cycles = 0;
  uart_rx_capture #(.CLKS_PER_BIT(N)) dut (
    .XCLK(clk),
    .XRESET_N(rst_n),
    .XUART_RX(line),
    .rx_data(data),
    .rx_valid(valid),
    .rx_ack(ack),
    .rx_frame_err(ferr),
    .rx_overrun(ovr),
`ifdef UART_RX_PARITY_EN
    .rx_parity_err(perr),
`endif
    .rx_busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (ferr) ferr_cycles <= ferr_cycles + 1;
    if (ovr) ovr_cycles <= ovr_cycles + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [10:0] frame(input logic [7:0] b, input logic stop);
`ifdef UART_RX_PARITY_EN
    return {stop, ^b, b, 1'b0};
`else
    return {1'b0, stop, b, 1'b0};
`endif
  endfunction
  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [10:0] f);
    for (int i = 0; i < NB; i++) begin
      line = f[i];
      idle(N);
    end
  endtask
  task automatic wait_valid(input string tag);
    int n = 0;
    while (!valid && n < 30 * N) begin
      idle(1);
      n++;
    end
    check(tag, 32'(valid), 1);
  endtask
  task automatic do_ack();
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
  endtask
  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    logic [7:0] q[$];
    logic [7:0] a, b;
    int n, f0, o0;
    idle(3);
    check("rst_data", 32'(data), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_ferr", 32'(ferr), 0);
    check("rst_ovr", 32'(ovr), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    idle(3);
    n = 0;
    fork
      send(frame(8'hA5, 1'b1));
      while (!valid && n < 400) begin
        idle(1);
        n++;
      end
    join
    check("lat", n, LAT);
    check("a5_data", 32'(data), 'hA5);
    do_ack();
    check("a5_ack", 32'(valid), 0);
    q = '{8'h00, 8'hFF};
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
    f0 = ferr_cycles;
    o0 = ovr_cycles;
    fork
      foreach (q[i]) send(frame(q[i], 1'b1));
      foreach (q[i]) begin
        wait_valid("b2b_valid");
        check("b2b_data", 32'(data), 32'(q[i]));
        do_ack();
      end
    join
    check("b2b_ferr", ferr_cycles - f0, 0);
    check("b2b_ovr", ovr_cycles - o0, 0);
    for (int i = 0; i < 4; i++) begin
      a = i == 0 ? 8'h3C : 8'($urandom);
      b = i == 0 ? 8'hC3 : 8'($urandom);
      send(frame(a, 1'b1));
      send(frame(b, 1'b1));
      check("ovr_data", 32'(data), 32'(a));
      check("ovr_valid", 32'(valid), 1);
      check("ovr_flag", 32'(ovr), 1);
      do_ack();
      check("ovr_ack_valid", 32'(valid), 0);
      check("ovr_ack_flag", 32'(ovr), 0);
    end
    send(frame(8'h3C, 1'b1));
    fork
      send(frame(8'hC3, 1'b1));
      begin
        idle(LAT - 1);
        ack = 1'b1;
        idle(1);
        ack = 1'b0;
      end
    join
    check("same_data", 32'(data), 'hC3);
    check("same_valid", 32'(valid), 1);
    check("same_ovr", 32'(ovr), 0);
    do_ack();
    f0 = ferr_cycles;
    line = 1'b0;
    idle(4);
    check("glitch_busy", 32'(busy), 1);
    line = 1'b1;
    idle(2 * N);
    check("glitch_idle", 32'(busy), 0);
    check("glitch_valid", 32'(valid), 0);
    check("glitch_ferr", ferr_cycles - f0, 0);
    f0 = ferr_cycles;
    send(frame(8'h55, 1'b0));
    line = 1'b1;
    idle(N);
    check("ferr_count", ferr_cycles - f0, 1);
    check("ferr_valid", 32'(valid), 0);
    f0 = ferr_cycles;
    line = 1'b0;
    idle(30 * N);
    line = 1'b1;
    idle(2 * N);
    check("break_count", ferr_cycles - f0, 1);
    check("break_valid", 32'(valid), 0);
    f0 = ferr_cycles;
    fork
      send(frame(8'hF1, 1'b1));
      begin
        idle(5 * N + 4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", 32'(data), 0);
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ovr", 32'(ovr), 0);
        idle(3);
        rst_n = 1'b1;
      end
    join
    idle(N);
    check("rst_lost", 32'(valid), 0);
    send(frame(8'h81, 1'b1));
    wait_valid("rst_81_valid");
    check("rst_81_data", 32'(data), 'h81);
    check("rst_81_ferr", ferr_cycles - f0, 0);
    do_ack();
`ifdef UART_RX_PARITY_EN
    send({1'b1, 1'b1, 8'h07, 1'b0});
    wait_valid("par_ok_valid");
    check("par_ok_data", 32'(data), 'h07);
    check("par_ok_err", 32'(perr), 0);
    do_ack();
    send({1'b1, 1'b0, 8'h07, 1'b0});
    wait_valid("par_bad_valid");
    check("par_bad_data", 32'(data), 'h07);
    check("par_bad_err", 32'(perr), 1);
    do_ack();
    check("par_ack_err", 32'(perr), 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
